// File: rtl/rf_frame_sequencer_if.sv
// Instruction handshake and register-file/streamer control bundle of the frame sequencer.
// The sequencer takes the master side; the front-end, register file and streamers take the slave side.
interface rf_frame_sequencer_if #(
  parameter int N_REGS = 16
);
  localparam int SW = $clog2(N_REGS);

  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_kind;
  logic [1:0]    instr_tr;
  logic [SW-1:0] instr_src1;
  logic [SW-1:0] instr_src2;
  logic [SW-1:0] instr_dst;
  logic          rf_rst;
  logic [1:0]    rf_op;
  logic [SW-1:0] rf_sel_in_1;
  logic [SW-1:0] rf_sel_in_2;
  logic [SW-1:0] rf_sel_in_3;
  logic [SW-1:0] rf_sel_out_1;
  logic [SW-1:0] rf_sel_out_2;
  logic [SW-1:0] rf_sel_out_3;
  logic          mac_en;
  logic          wb_en;
  logic          ld_en;
  logic          st_en;
  logic          busy;
  logic          err;

  modport master (
    input  instr_valid, instr_kind, instr_tr, instr_src1, instr_src2, instr_dst,
    output instr_ready, rf_rst, rf_op,
    output rf_sel_in_1, rf_sel_in_2, rf_sel_in_3,
    output rf_sel_out_1, rf_sel_out_2, rf_sel_out_3,
    output mac_en, wb_en, ld_en, st_en, busy, err
  );

  modport slave (
    output instr_valid, instr_kind, instr_tr, instr_src1, instr_src2, instr_dst,
    input  instr_ready, rf_rst, rf_op,
    input  rf_sel_in_1, rf_sel_in_2, rf_sel_in_3,
    input  rf_sel_out_1, rf_sel_out_2, rf_sel_out_3,
    input  mac_en, wb_en, ld_en, st_en, busy, err
  );
endinterface

// File: rtl/rf_frame_sequencer.sv
// Issues one register-file instruction per N-cycle frame, aligned to the register file row tick,
// schedules MAC write-backs LAT cycles later and stalls issue on scoreboard hazards.
module rf_frame_sequencer #(
  parameter int N       = 4,
  parameter int N_REGS  = 16,
  parameter int LAT     = 4,
  parameter int SCRATCH = N_REGS - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_frame_sequencer_if.master bus
);
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int SW    = $clog2(N_REGS);
  localparam int DEPTH = LAT / N;
  localparam logic [1:0]    K_NOP   = 2'b00;
  localparam logic [1:0]    K_LOAD  = 2'b01;
  localparam logic [1:0]    K_STORE = 2'b10;
  localparam logic [1:0]    K_COMP  = 2'b11;
  localparam logic [SW-1:0] SCR     = SW'(SCRATCH);
  localparam logic [PW-1:0] P_LAST  = PW'(N - 1);

  logic [PW-1:0]     r_p;
  logic              r_buf_vld;
  logic [1:0]        r_buf_kind, r_buf_tr;
  logic [SW-1:0]     r_buf_src1, r_buf_src2, r_buf_dst;
  logic [1:0]        r_slot_kind, r_slot_tr;
  logic [SW-1:0]     r_slot_src1, r_slot_src2, r_slot_dst;
  logic [DEPTH-1:0]  r_wb_vld;
  logic [SW-1:0]     r_wb_dst [DEPTH];
  logic [N_REGS-1:0] r_sb;
  logic              r_err;

  logic              w_last, w_hazard, w_promote, w_ready, w_accept, w_scr_ref, w_take;
  logic [N_REGS-1:0] w_sb_set, w_sb_clr;

  function automatic logic uses_scratch(input logic [1:0] kind,
                                        input logic [SW-1:0] s1, s2, d);
    case (kind)
      K_LOAD:  return d == SCR;
      K_STORE: return s1 == SCR;
      K_COMP:  return (s1 == SCR) || (s2 == SCR) || (d == SCR);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic hits(input logic [N_REGS-1:0] sb, input logic [1:0] kind,
                                input logic [SW-1:0] s1, s2, d);
    case (kind)
      K_LOAD:  return sb[d];
      K_STORE: return sb[s1];
      K_COMP:  return sb[s1] | sb[s2] | sb[d];
      default: return 1'b0;
    endcase
  endfunction

  assign w_last    = (r_p == P_LAST);
  assign w_hazard  = hits(r_sb, r_buf_kind, r_buf_src1, r_buf_src2, r_buf_dst);
  assign w_promote = w_last & r_buf_vld & ~w_hazard;
  assign w_ready   = ~r_buf_vld | w_promote;
  assign w_accept  = bus.instr_valid & w_ready;
  assign w_scr_ref = uses_scratch(bus.instr_kind, bus.instr_src1, bus.instr_src2, bus.instr_dst);
  assign w_take    = w_accept & (bus.instr_kind != K_NOP) & ~w_scr_ref;

  // Scoreboard update: release at the edge ending the write-back frame, set on COMPUTE promotion
  always_comb begin
    w_sb_clr = '0;
    w_sb_set = '0;
    if (w_last && r_wb_vld[DEPTH-1]) w_sb_clr[r_wb_dst[DEPTH-1]] = 1'b1;
    if (w_promote && (r_buf_kind == K_COMP)) w_sb_set[r_buf_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p         <= '0;
      r_buf_vld   <= 1'b0;
      r_slot_kind <= K_NOP;
      r_wb_vld    <= '0;
      r_sb        <= '0;
      r_err       <= 1'b0;
    end else begin
      r_p <= w_last ? '0 : r_p + PW'(1);
      if (w_take)         r_buf_vld <= 1'b1;
      else if (w_promote) r_buf_vld <= 1'b0;
      if (w_accept && (bus.instr_kind != K_NOP) && w_scr_ref) r_err <= 1'b1;
      r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
      if (w_last) begin
        r_slot_kind <= w_promote ? r_buf_kind : K_NOP;
        for (int i = DEPTH - 1; i > 0; i--) r_wb_vld[i] <= r_wb_vld[i-1];
        r_wb_vld[0] <= (r_slot_kind == K_COMP);
      end
    end
  end

  // Operand/destination fields carry no reset; every use is qualified by a valid or kind
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_buf_kind <= bus.instr_kind;
      r_buf_tr   <= bus.instr_tr;
      r_buf_src1 <= bus.instr_src1;
      r_buf_src2 <= bus.instr_src2;
      r_buf_dst  <= bus.instr_dst;
    end
    if (w_last) begin
      r_slot_tr   <= r_buf_tr;
      r_slot_src1 <= r_buf_src1;
      r_slot_src2 <= r_buf_src2;
      r_slot_dst  <= r_buf_dst;
      for (int i = DEPTH - 1; i > 0; i--) r_wb_dst[i] <= r_wb_dst[i-1];
      r_wb_dst[0] <= r_slot_dst;
    end
  end

  always_comb begin
    bus.rf_op        = 2'b00;
    bus.rf_sel_in_1  = SCR;
    bus.rf_sel_in_2  = SCR;
    bus.rf_sel_in_3  = SCR;
    bus.rf_sel_out_1 = SCR;
    bus.rf_sel_out_2 = SCR;
    bus.rf_sel_out_3 = SCR;
    bus.mac_en       = 1'b0;
    bus.wb_en        = 1'b0;
    bus.ld_en        = 1'b0;
    bus.st_en        = 1'b0;
    case (r_slot_kind)
      K_LOAD: begin
        bus.rf_sel_in_3 = r_slot_dst;
        bus.ld_en       = 1'b1;
      end
      K_STORE: begin
        bus.rf_sel_out_3 = r_slot_src1;
        bus.st_en        = 1'b1;
      end
      K_COMP: begin
        bus.rf_sel_out_1 = r_slot_src1;
        bus.rf_sel_out_2 = r_slot_src2;
        bus.rf_op        = r_slot_tr;
        bus.mac_en       = 1'b1;
      end
      default: ;
    endcase
    if (r_wb_vld[DEPTH-1]) begin
      bus.rf_sel_in_1 = r_wb_dst[DEPTH-1];
      bus.wb_en       = 1'b1;
    end
  end

  assign bus.rf_rst      = rst;
  assign bus.instr_ready = w_ready;
  assign bus.err         = r_err;
  assign bus.busy        = r_buf_vld | (r_slot_kind != K_NOP) | (|r_wb_vld) | (|r_sb);
endmodule

// File: tb/tb_rf_frame_sequencer.sv
// Directed bench for rf_frame_sequencer: single-instruction vector table plus hand-written
// back-to-back hazard, streaming and mid-frame reset sequences.
module tb_rf_frame_sequencer;
  localparam int N = 4;
  localparam logic [1:0] K_NOP = 2'b00, K_LOAD = 2'b01, K_STORE = 2'b10, K_COMP = 2'b11;

  typedef logic [29:0] ovec_t;
  localparam ovec_t IDLE = 30'h00FF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_frame_sequencer_if #(.N_REGS(16)) bus ();
  rf_frame_sequencer #(.N(N), .N_REGS(16), .LAT(4), .SCRATCH(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int tb_p   = 0;

  // Independent model of the frame phase
  always @(posedge clk) tb_p <= rst ? 0 : (tb_p + 1) % N;

  function automatic ovec_t mk(input logic ld, st, mac, wb, input logic [1:0] op,
                               input logic [3:0] so1, so2, so3, si1, si2, si3);
    return {ld, st, mac, wb, op, so1, so2, so3, si1, si2, si3};
  endfunction

  function automatic ovec_t dut_out();
    return {bus.ld_en, bus.st_en, bus.mac_en, bus.wb_en, bus.rf_op,
            bus.rf_sel_out_1, bus.rf_sel_out_2, bus.rf_sel_out_3,
            bus.rf_sel_in_1, bus.rf_sel_in_2, bus.rf_sel_in_3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [1:0] tr,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d);
    bus.instr_valid = v;
    bus.instr_kind  = k;
    bus.instr_tr    = tr;
    bus.instr_src1  = s1;
    bus.instr_src2  = s2;
    bus.instr_dst   = d;
  endtask

  task automatic rst_state(input string name);
    chk({name, "_rfrst"}, bus.rf_rst, 1);
    chk({name, "_out"},   dut_out(), IDLE);
    chk({name, "_ready"}, bus.instr_ready, 1);
    chk({name, "_busy"},  bus.busy, 0);
    chk({name, "_err"},   bus.err, 0);
  endtask

  // Enter at a negedge; leave at the negedge where rst has just been released (p=0)
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    drive(0, K_NOP, 0, 0, 0, 0);
    @(negedge clk);
    rst_state(name);
    rst = 1'b0;
  endtask

  task automatic wait_p(input int target);
    for (int i = 0; i < N && tb_p != target; i++) @(negedge clk);
  endtask

  // Enter at negedge with p=0; check every cycle of the frame; leave at next p=0
  task automatic run_frame(input string name, input ovec_t exp, output logic [N-1:0] rdy);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_p%0d", name, i), dut_out(), exp);
      rdy[i] = bus.instr_ready;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0] k;
    logic [1:0] tr;
    logic [3:0] s1, s2, d;
    ovec_t      ex1;
    ovec_t      ex2;
    logic       err;
  } vec_t;

  vec_t tbl [8];
  logic [N-1:0] rdy;

  initial begin
    drive(0, K_NOP, 0, 0, 0, 0);
    tbl[0] = '{K_LOAD,  2'b00, 0, 0, 2,  mk(1,0,0,0,0,15,15,15,15,15,2),  IDLE, 1'b0};
    tbl[1] = '{K_STORE, 2'b00, 5, 0, 0,  mk(0,1,0,0,0,15,15,5,15,15,15),  IDLE, 1'b0};
    tbl[2] = '{K_COMP,  2'b10, 2, 3, 1,  mk(0,0,1,0,2,2,3,15,15,15,15),
               mk(0,0,0,1,0,15,15,15,1,15,15), 1'b0};
    tbl[3] = '{K_COMP,  2'b01, 4, 7, 9,  mk(0,0,1,0,1,4,7,15,15,15,15),
               mk(0,0,0,1,0,15,15,15,9,15,15), 1'b0};
    tbl[4] = '{K_LOAD,  2'b00, 0, 0, 15, IDLE, IDLE, 1'b1};
    tbl[5] = '{K_COMP,  2'b00, 1, 15, 3, IDLE, IDLE, 1'b1};
    tbl[6] = '{K_NOP,   2'b00, 15, 15, 15, IDLE, IDLE, 1'b0};
    tbl[7] = '{K_STORE, 2'b00, 0, 15, 15, mk(0,1,0,0,0,15,15,0,15,15,15), IDLE, 1'b0};

    for (int v = 0; v < 8; v++) begin
      do_reset($sformatf("v%0d_rst", v));
      wait_p(1);
      drive(1, tbl[v].k, tbl[v].tr, tbl[v].s1, tbl[v].s2, tbl[v].d);
      chk($sformatf("v%0d_accept", v), bus.instr_ready, 1);
      @(negedge clk);
      drive(0, K_NOP, 0, 0, 0, 0);
      chk($sformatf("v%0d_busy_buf", v), bus.busy, (tbl[v].ex1 != IDLE));
      wait_p(0);
      run_frame($sformatf("v%0d_exec", v), tbl[v].ex1, rdy);
      run_frame($sformatf("v%0d_wb", v), tbl[v].ex2, rdy);
      chk($sformatf("v%0d_busy_end", v), bus.busy, 0);
      chk($sformatf("v%0d_err", v), bus.err, tbl[v].err);
    end

    // Back-to-back COMPUTE with RAW hazard on R1, plus a third instruction waiting
    do_reset("b2b_rst");
    wait_p(1);
    drive(1, K_COMP, 2'b10, 2, 3, 1);
    @(negedge clk);
    chk("b2b_rdy_p2", bus.instr_ready, 0);
    drive(1, K_COMP, 2'b00, 1, 1, 4);
    @(negedge clk);
    chk("b2b_rdy_p3", bus.instr_ready, 1);
    @(negedge clk);
    drive(1, K_LOAD, 0, 0, 0, 8);
    run_frame("b2b_F",  mk(0,0,1,0,2,2,3,15,15,15,15), rdy);
    chk("b2b_rdy_F", rdy, 4'b0000);
    run_frame("b2b_F1", mk(0,0,0,1,0,15,15,15,1,15,15), rdy);
    chk("b2b_rdy_F1", rdy, 4'b0000);
    run_frame("b2b_F2", IDLE, rdy);
    chk("b2b_rdy_F2", rdy, 4'b1000);
    drive(0, K_NOP, 0, 0, 0, 0);
    run_frame("b2b_F3", mk(0,0,1,0,0,1,1,15,15,15,15), rdy);
    chk("b2b_rdy_F3", rdy, 4'b1000);
    run_frame("b2b_F4", mk(1,0,0,1,0,15,15,15,4,15,8), rdy);
    chk("b2b_rdy_F4", rdy, 4'b1111);
    chk("b2b_busy_end", bus.busy, 0);

    // STORE then two LOADs with valid held continuously: no idle frame between them
    do_reset("str_rst");
    wait_p(1);
    drive(1, K_STORE, 0, 5, 0, 0);
    @(negedge clk);
    drive(1, K_LOAD, 0, 0, 0, 6);
    wait_p(0);
    drive(1, K_LOAD, 0, 0, 0, 7);
    run_frame("str_F", mk(0,1,0,0,0,15,15,5,15,15,15), rdy);
    chk("str_rdy_F", rdy, 4'b1000);
    drive(0, K_NOP, 0, 0, 0, 0);
    run_frame("str_F1", mk(1,0,0,0,0,15,15,15,15,15,6), rdy);
    chk("str_rdy_F1", rdy, 4'b1000);
    run_frame("str_F2", mk(1,0,0,0,0,15,15,15,15,15,7), rdy);
    chk("str_rdy_F2", rdy, 4'b1111);
    chk("str_busy_end", bus.busy, 0);

    // Sticky err survives later traffic until reset
    drive(1, K_STORE, 0, 15, 0, 0);
    @(negedge clk);
    drive(1, K_LOAD, 0, 0, 0, 3);
    @(negedge clk);
    drive(0, K_NOP, 0, 0, 0, 0);
    for (int i = 0; i < 2 * N; i++) @(negedge clk);
    chk("err_sticky", bus.err, 1);

    // Reset at p=2 of a COMPUTE frame with its write-back pending
    do_reset("mid_rst0");
    wait_p(1);
    drive(1, K_COMP, 2'b10, 2, 3, 1);
    @(negedge clk);
    drive(0, K_NOP, 0, 0, 0, 0);
    wait_p(0);
    chk("mid_mac", bus.mac_en, 1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_pre", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst_state("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after_out", dut_out(), IDLE);
    chk("mid_after_busy", bus.busy, 0);
    drive(1, K_LOAD, 0, 0, 0, 1);
    chk("mid_ld_accept", bus.instr_ready, 1);
    @(negedge clk);
    drive(0, K_NOP, 0, 0, 0, 0);
    wait_p(0);
    run_frame("mid_ld", mk(1,0,0,0,0,15,15,15,15,15,1), rdy);
    run_frame("mid_idle", IDLE, rdy);
    chk("mid_busy_end", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
